// File: rtl/relogio_contador.sv
// Running HH:MM:SS BCD clock fed by the adjustment block's digit outputs.
// Optional RELOGIO_DAY_PULSE_EN adds a day_wrap pulse on the 23:59:59 rollover.
module relogio_contador #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ajMod,
    input  logic [3:0] hou_tens_in,
    input  logic [3:0] hou_units_in,
    input  logic [3:0] min_tens_in,
    input  logic [3:0] min_units_in,
    input  logic [3:0] sec_tens_in,
    input  logic [3:0] sec_units_in,
    output logic [3:0] hou_tens,
    output logic [3:0] hou_units,
    output logic [3:0] min_tens,
    output logic [3:0] min_units,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_units,
    output logic       sec_pulse,
    output logic       load_err
`ifdef RELOGIO_DAY_PULSE_EN
    ,
    output logic       day_wrap
`endif
);

    localparam int DIV_W = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_HZ - 1);
    localparam logic [3:0] BLANK = 4'hF;

    logic [DIV_W-1:0] r_div;
    logic             r_ajModQ;
    logic [3:0]       r_shHouTens, r_shHouUnits, r_shMinTens;
    logic [3:0]       r_shMinUnits, r_shSecTens, r_shSecUnits;

    logic       w_secWrap, w_minWrap, w_hourWrap;
    logic [3:0] w_nHouTens, w_nHouUnits, w_nMinTens, w_nMinUnits, w_nSecTens, w_nSecUnits;
    logic       w_houOk, w_minOk, w_secOk;

    // Next time-of-day after one second, with BCD carries rippling sec -> min -> hour.
    always_comb begin
        w_secWrap   = (sec_tens == 4'd5) && (sec_units == 4'd9);
        w_minWrap   = (min_tens == 4'd5) && (min_units == 4'd9);
        w_hourWrap  = (hou_tens == 4'd2) && (hou_units == 4'd3);
        w_nSecUnits = (sec_units == 4'd9) ? 4'd0 : sec_units + 4'd1;
        w_nSecTens  = sec_tens;
        w_nMinUnits = min_units;
        w_nMinTens  = min_tens;
        w_nHouUnits = hou_units;
        w_nHouTens  = hou_tens;
        if (sec_units == 4'd9) begin
            w_nSecTens = w_secWrap ? 4'd0 : sec_tens + 4'd1;
        end
        if (w_secWrap) begin
            w_nMinUnits = (min_units == 4'd9) ? 4'd0 : min_units + 4'd1;
            if (min_units == 4'd9) begin
                w_nMinTens = w_minWrap ? 4'd0 : min_tens + 4'd1;
            end
        end
        if (w_secWrap && w_minWrap) begin
            if (w_hourWrap) begin
                w_nHouTens  = 4'd0;
                w_nHouUnits = 4'd0;
            end else if (hou_units == 4'd9) begin
                w_nHouTens  = hou_tens + 4'd1;
                w_nHouUnits = 4'd0;
            end else begin
                w_nHouUnits = hou_units + 4'd1;
            end
        end
    end

    always_comb begin
        w_houOk = (r_shHouTens <= 4'd2) && (r_shHouUnits <= 4'd9) &&
                  ((r_shHouTens < 4'd2) || (r_shHouUnits <= 4'd3));
        w_minOk = (r_shMinTens <= 4'd5) && (r_shMinUnits <= 4'd9);
        w_secOk = (r_shSecTens <= 4'd5) && (r_shSecUnits <= 4'd9);
    end

    // Priority: reset, then capture/freeze, then commit on ajMod falling, then counting.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div        <= '0;
            r_ajModQ     <= 1'b0;
            r_shHouTens  <= 4'd0;
            r_shHouUnits <= 4'd0;
            r_shMinTens  <= 4'd0;
            r_shMinUnits <= 4'd0;
            r_shSecTens  <= 4'd0;
            r_shSecUnits <= 4'd0;
            hou_tens     <= 4'd0;
            hou_units    <= 4'd0;
            min_tens     <= 4'd0;
            min_units    <= 4'd0;
            sec_tens     <= 4'd0;
            sec_units    <= 4'd0;
            sec_pulse    <= 1'b0;
            load_err     <= 1'b0;
`ifdef RELOGIO_DAY_PULSE_EN
            day_wrap     <= 1'b0;
`endif
        end else if (ajMod) begin
            r_ajModQ  <= 1'b1;
            r_div     <= '0;
            sec_pulse <= 1'b0;
            load_err  <= 1'b0;
`ifdef RELOGIO_DAY_PULSE_EN
            day_wrap  <= 1'b0;
`endif
            if (hou_tens_in  != BLANK) r_shHouTens  <= hou_tens_in;
            if (hou_units_in != BLANK) r_shHouUnits <= hou_units_in;
            if (min_tens_in  != BLANK) r_shMinTens  <= min_tens_in;
            if (min_units_in != BLANK) r_shMinUnits <= min_units_in;
            if (sec_tens_in  != BLANK) r_shSecTens  <= sec_tens_in;
            if (sec_units_in != BLANK) r_shSecUnits <= sec_units_in;
        end else if (r_ajModQ) begin
            r_ajModQ  <= 1'b0;
            r_div     <= '0;
            sec_pulse <= 1'b0;
            load_err  <= !(w_houOk && w_minOk && w_secOk);
`ifdef RELOGIO_DAY_PULSE_EN
            day_wrap  <= 1'b0;
`endif
            if (w_houOk) begin
                hou_tens  <= r_shHouTens;
                hou_units <= r_shHouUnits;
            end
            if (w_minOk) begin
                min_tens  <= r_shMinTens;
                min_units <= r_shMinUnits;
            end
            if (w_secOk) begin
                sec_tens  <= r_shSecTens;
                sec_units <= r_shSecUnits;
            end
        end else begin
            load_err <= 1'b0;
            if (r_div == DIV_LAST) begin
                r_div     <= '0;
                sec_pulse <= 1'b1;
                hou_tens  <= w_nHouTens;
                hou_units <= w_nHouUnits;
                min_tens  <= w_nMinTens;
                min_units <= w_nMinUnits;
                sec_tens  <= w_nSecTens;
                sec_units <= w_nSecUnits;
`ifdef RELOGIO_DAY_PULSE_EN
                day_wrap  <= w_secWrap && w_minWrap && w_hourWrap;
`endif
            end else begin
                r_div     <= r_div + DIV_W'(1);
                sec_pulse <= 1'b0;
`ifdef RELOGIO_DAY_PULSE_EN
                day_wrap  <= 1'b0;
`endif
            end
        end
    end

endmodule
